// File: rtl/parking_pkg.sv
// Shared types and sizing for the parking-lot occupancy blocks.
// Slot indices, timer width and the entry-gate state encoding live here.
package parking_pkg;

   localparam int NUM_SLOTS = 8;
   localparam int SLOT_W    = 3;
   localparam int TIMER_W   = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OPEN  = 2'd1,
      CLOSE = 2'd2
   } state_t;

   // One-hot mask selecting a single space in the occupancy bitmap.
   function automatic logic [NUM_SLOTS-1:0] slot_mask(input logic [SLOT_W-1:0] idx);
      logic [NUM_SLOTS-1:0] m;
      m      = '0;
      m[idx] = 1'b1;
      return m;
   endfunction

endpackage

// File: rtl/lowest_free_slot.sv
// Priority encoder returning the lowest-numbered free (0) space of a bitmap.
// Index 0 has the highest priority; none_free flags a completely full lot.
module lowest_free_slot
   import parking_pkg::*;
(
   input  logic [NUM_SLOTS-1:0] bitmap,
   output logic [SLOT_W-1:0]    index,
   output logic                 none_free
);

   // Scan from the top down so the lowest free index is the last one written.
   always_comb begin
      index     = '0;
      none_free = 1'b1;
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
         if (!bitmap[i]) begin
            index     = SLOT_W'(i);
            none_free = 1'b0;
         end
      end
   end

endmodule

// File: rtl/slot_tracker.sv
// Occupancy tracker for the 8-space lot: allocates the lowest free space on arrival,
// runs the entry-gate handshake with timeout, and keeps the registered occupancy bitmap.
module slot_tracker
   import parking_pkg::*;
#(
   parameter int GATE_TIMEOUT = 15   // legal range 1..15
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 arrive,
   input  logic                 gate_done,
   input  logic                 depart,
   input  logic [SLOT_W-1:0]    depart_slot,
   output logic [NUM_SLOTS-1:0] new_capacity,
   output logic [SLOT_W-1:0]    assigned_slot,
   output logic                 gate_open,
   output logic                 full,
   output logic                 reject,
   output logic                 timeout,
   output logic                 depart_err
);

   localparam logic [TIMER_W-1:0] LAST_CNT = TIMER_W'(GATE_TIMEOUT - 1);

   state_t               state_q, state_d;
   logic [TIMER_W-1:0]   cnt_q, cnt_d;
   logic [NUM_SLOTS-1:0] bitmap_q, bitmap_d;
   logic [SLOT_W-1:0]    slot_q, slot_d;
   logic                 gate_open_q, gate_open_d;
   logic                 reject_q, reject_d;
   logic                 timeout_q, timeout_d;
   logic                 depart_err_q, depart_err_d;

   logic [NUM_SLOTS-1:0] set_mask;
   logic [NUM_SLOTS-1:0] clr_mask;
   logic [SLOT_W-1:0]    free_idx;
   logic                 none_free;

   lowest_free_slot u_lowest_free (
      .bitmap    (bitmap_q),
      .index     (free_idx),
      .none_free (none_free)
   );

   // Departures are judged against the registered bitmap, so a reserved but
   // uncommitted space still reads as free and is reported as an error.
   always_comb begin
      clr_mask     = '0;
      depart_err_d = 1'b0;
      if (depart) begin
         if (bitmap_q[depart_slot]) begin
            clr_mask = slot_mask(depart_slot);
         end else begin
            depart_err_d = 1'b1;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      slot_d    = slot_q;
      set_mask  = '0;
      reject_d  = 1'b0;
      timeout_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (arrive) begin
               if (none_free) begin
                  reject_d = 1'b1;
               end else begin
                  slot_d  = free_idx;
                  cnt_d   = '0;
                  state_d = OPEN;
               end
            end
         end

         OPEN: begin
            reject_d = arrive;
            // A gate_done in the last permitted cycle takes priority over timeout.
            if (gate_done) begin
               set_mask = slot_mask(slot_q);
               state_d  = CLOSE;
            end else if (cnt_q == LAST_CNT) begin
               timeout_d = 1'b1;
               state_d   = CLOSE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         CLOSE: begin
            reject_d = arrive;
            state_d  = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      bitmap_d    = (bitmap_q | set_mask) & ~clr_mask;
      gate_open_d = (state_d == OPEN);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         bitmap_q     <= '0;
         slot_q       <= '0;
         gate_open_q  <= 1'b0;
         reject_q     <= 1'b0;
         timeout_q    <= 1'b0;
         depart_err_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         bitmap_q     <= bitmap_d;
         slot_q       <= slot_d;
         gate_open_q  <= gate_open_d;
         reject_q     <= reject_d;
         timeout_q    <= timeout_d;
         depart_err_q <= depart_err_d;
      end
   end

   assign new_capacity  = bitmap_q;
   assign assigned_slot = slot_q;
   assign gate_open     = gate_open_q;
   assign full          = &bitmap_q;
   assign reject        = reject_q;
   assign timeout       = timeout_q;
   assign depart_err    = depart_err_q;

endmodule

// File: tb/tb_slot_tracker.sv
// Self-checking bench for slot_tracker: directed vector table, hand-written corner
// sequences, then random traffic checked against a behavioural lot model.
module tb_slot_tracker;

   localparam int TMO = 15;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       arrive = 1'b0;
   logic       gate_done = 1'b0;
   logic       depart = 1'b0;
   logic [2:0] depart_slot = 3'd0;
   logic [7:0] new_capacity;
   logic [2:0] assigned_slot;
   logic       gate_open, full, reject, timeout, depart_err;

   slot_tracker #(.GATE_TIMEOUT(TMO)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .arrive        (arrive),
      .gate_done     (gate_done),
      .depart        (depart),
      .depart_slot   (depart_slot),
      .new_capacity  (new_capacity),
      .assigned_slot (assigned_slot),
      .gate_open     (gate_open),
      .full          (full),
      .reject        (reject),
      .timeout       (timeout),
      .depart_err    (depart_err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Behavioural model: which spaces are taken, whether a car is being let in
   // (and for how many cycles), and the one-cycle cool-down after the gate.
   logic [7:0] m_map;
   logic [2:0] m_slot;
   bit         m_open, m_close;
   int         m_age;
   bit         e_reject, e_timeout, e_derr;

   typedef struct {
      logic       a, g, d;
      logic [2:0] ds;
      logic [7:0] cap;
      logic [2:0] slot;
      logic       open, rej, tmo, derr;
   } vec_t;
   vec_t vt[16];

   task automatic check1(string name, logic act, logic exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check3(string name, logic [2:0] act, logic [2:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check8(string name, logic [7:0] act, logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %02h expected %02h", name, act, exp);
      end
   endtask

   task automatic check_int(string name, int act, int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_map     = 8'h00;
      m_slot    = 3'd0;
      m_open    = 1'b0;
      m_close   = 1'b0;
      m_age     = 0;
      e_reject  = 1'b0;
      e_timeout = 1'b0;
      e_derr    = 1'b0;
   endtask

   task automatic model_step(logic a, logic g, logic d, logic [2:0] ds);
      logic [7:0] pre;
      logic [7:0] set_b;
      logic [7:0] clr_b;
      pre       = m_map;
      set_b     = 8'h00;
      clr_b     = 8'h00;
      e_reject  = 1'b0;
      e_timeout = 1'b0;
      e_derr    = 1'b0;
      if (d) begin
         if (pre[ds]) clr_b[ds] = 1'b1;
         else         e_derr = 1'b1;
      end
      if (m_open) begin
         if (a) e_reject = 1'b1;
         if (g) begin
            set_b[m_slot] = 1'b1;
            m_open  = 1'b0;
            m_close = 1'b1;
         end else begin
            m_age++;
            if (m_age == TMO) begin
               e_timeout = 1'b1;
               m_open    = 1'b0;
               m_close   = 1'b1;
            end
         end
      end else if (m_close) begin
         if (a) e_reject = 1'b1;
         m_close = 1'b0;
      end else if (a) begin
         if (pre == 8'hFF) begin
            e_reject = 1'b1;
         end else begin
            for (int i = 7; i >= 0; i--) if (!pre[i]) m_slot = 3'(i);
            m_open = 1'b1;
            m_age  = 0;
         end
      end
      m_map = (pre | set_b) & ~clr_b;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      model_step(arrive, gate_done, depart, depart_slot);
      arrive    = 1'b0;
      gate_done = 1'b0;
      depart    = 1'b0;
   endtask

   task automatic check_model(string tag);
      check8({tag, ".cap"},  new_capacity,  m_map);
      check3({tag, ".slot"}, assigned_slot, m_slot);
      check1({tag, ".open"}, gate_open,     m_open);
      check1({tag, ".full"}, full,          m_map == 8'hFF);
      check1({tag, ".rej"},  reject,        e_reject);
      check1({tag, ".tmo"},  timeout,       e_timeout);
      check1({tag, ".derr"}, depart_err,    e_derr);
   endtask

   task automatic tick_chk(string tag);
      tick();
      check_model(tag);
   endtask

   task automatic park_one(string tag);
      arrive = 1'b1;
      tick_chk(tag);
      gate_done = 1'b1;
      tick_chk(tag);
      tick_chk(tag);
   endtask

   task automatic reset_dut();
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic add(int i, int a, int g, int d, int ds, int cap, int slot,
                      int open, int rej, int tmo, int derr);
      vt[i].a    = a[0];
      vt[i].g    = g[0];
      vt[i].d    = d[0];
      vt[i].ds   = ds[2:0];
      vt[i].cap  = cap[7:0];
      vt[i].slot = slot[2:0];
      vt[i].open = open[0];
      vt[i].rej  = rej[0];
      vt[i].tmo  = tmo[0];
      vt[i].derr = derr[0];
   endtask

   initial begin
      int opens;
      int tmo_cnt;
      model_reset();

      //        i  a  g  d ds  cap   sl op rj to de
      add( 0, 1, 0, 0, 0, 8'h00, 0, 1, 0, 0, 0);
      add( 1, 0, 0, 0, 0, 8'h00, 0, 1, 0, 0, 0);
      add( 2, 0, 0, 0, 0, 8'h00, 0, 1, 0, 0, 0);
      add( 3, 0, 1, 0, 0, 8'h01, 0, 0, 0, 0, 0);
      add( 4, 0, 0, 0, 0, 8'h01, 0, 0, 0, 0, 0);
      add( 5, 1, 0, 0, 0, 8'h01, 1, 1, 0, 0, 0);
      add( 6, 0, 0, 0, 0, 8'h01, 1, 1, 0, 0, 0);
      add( 7, 0, 0, 0, 0, 8'h01, 1, 1, 0, 0, 0);
      add( 8, 0, 1, 0, 0, 8'h03, 1, 0, 0, 0, 0);
      add( 9, 1, 0, 0, 0, 8'h03, 1, 0, 1, 0, 0);
      add(10, 1, 0, 0, 0, 8'h03, 2, 1, 0, 0, 0);
      add(11, 1, 0, 0, 0, 8'h03, 2, 1, 1, 0, 0);
      add(12, 0, 1, 1, 0, 8'h06, 2, 0, 0, 0, 0);
      add(13, 0, 0, 1, 0, 8'h06, 2, 0, 0, 0, 1);
      add(14, 0, 0, 1, 2, 8'h02, 2, 0, 0, 0, 0);
      add(15, 0, 1, 0, 0, 8'h02, 2, 0, 0, 0, 0);

      // Reset state
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_model("reset");
      rst_n = 1'b1;

      // Directed vector table
      for (int i = 0; i < 16; i++) begin
         string tag;
         tag         = $sformatf("vec%0d", i);
         arrive      = vt[i].a;
         gate_done   = vt[i].g;
         depart      = vt[i].d;
         depart_slot = vt[i].ds;
         tick();
         check8({tag, ".cap"},  new_capacity,  vt[i].cap);
         check3({tag, ".slot"}, assigned_slot, vt[i].slot);
         check1({tag, ".open"}, gate_open,     vt[i].open);
         check1({tag, ".full"}, full,          vt[i].cap == 8'hFF);
         check1({tag, ".rej"},  reject,        vt[i].rej);
         check1({tag, ".tmo"},  timeout,       vt[i].tmo);
         check1({tag, ".derr"}, depart_err,    vt[i].derr);
      end

      // Fill the lot, reject when full, free space 5 and reallocate it
      reset_dut();
      for (int k = 0; k < 8; k++) park_one("fill");
      check8("fill.cap_ff", new_capacity, 8'hFF);
      check1("fill.full", full, 1'b1);
      arrive = 1'b1;
      tick_chk("full_arr");
      check1("full_arr.reject", reject, 1'b1);
      check1("full_arr.gate", gate_open, 1'b0);
      depart = 1'b1; depart_slot = 3'd5;
      tick_chk("dep5");
      check8("dep5.cap", new_capacity, 8'hDF);
      check1("dep5.full", full, 1'b0);
      arrive = 1'b1;
      tick_chk("realloc");
      check3("realloc.slot", assigned_slot, 3'd5);
      gate_done = 1'b1;
      tick_chk("realloc");
      tick_chk("realloc");

      // Timeout: gate held exactly TMO cycles, one timeout pulse, bitmap unchanged
      depart = 1'b1; depart_slot = 3'd0;
      tick_chk("tmo_prep");
      arrive = 1'b1;
      tick_chk("tmo");
      opens   = 0;
      tmo_cnt = 0;
      for (int j = 0; j < 40; j++) begin
         if (gate_open) opens++;
         tick_chk("tmo");
         if (timeout) tmo_cnt++;
      end
      check_int("tmo.open_cycles", opens, TMO);
      check_int("tmo.pulses", tmo_cnt, 1);
      check8("tmo.cap", new_capacity, 8'hFE);

      // gate_done in the final permitted cycle commits without timeout
      arrive = 1'b1;
      tick_chk("last");
      repeat (TMO - 1) tick_chk("last");
      check1("last.still_open", gate_open, 1'b1);
      gate_done = 1'b1;
      tick_chk("last");
      check1("last.no_tmo", timeout, 1'b0);
      check8("last.cap", new_capacity, 8'hFF);
      tick_chk("last");
      check1("last.no_tmo2", timeout, 1'b0);

      // Departure of a free space, arrival in OPEN, commit + depart same cycle
      reset_dut();
      for (int k = 0; k < 3; k++) park_one("err");
      depart = 1'b1; depart_slot = 3'd1;
      tick_chk("err");
      check8("err.cap05", new_capacity, 8'h05);
      depart = 1'b1; depart_slot = 3'd1;
      tick_chk("err");
      check1("err.derr", depart_err, 1'b1);
      check8("err.cap_kept", new_capacity, 8'h05);
      arrive = 1'b1;
      tick_chk("same");
      check3("same.slot", assigned_slot, 3'd1);
      arrive = 1'b1;
      tick_chk("same");
      check1("same.reject", reject, 1'b1);
      check3("same.slot_kept", assigned_slot, 3'd1);
      check1("same.open_kept", gate_open, 1'b1);
      gate_done = 1'b1; depart = 1'b1; depart_slot = 3'd0;
      tick_chk("same");
      check8("same.cap06", new_capacity, 8'h06);
      tick_chk("same");

      // Reset asserted mid-handshake
      reset_dut();
      for (int k = 0; k < 6; k++) park_one("rst");
      depart = 1'b1; depart_slot = 3'd0;
      tick_chk("rst");
      depart = 1'b1; depart_slot = 3'd1;
      tick_chk("rst");
      check8("rst.cap3c", new_capacity, 8'h3C);
      arrive = 1'b1;
      tick_chk("rst");
      check1("rst.open", gate_open, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check1("rst.open_drop", gate_open, 1'b0);
      check8("rst.cap_clear", new_capacity, 8'h00);
      check1("rst.full", full, 1'b0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      arrive = 1'b1;
      tick_chk("rst_after");
      check3("rst_after.slot", assigned_slot, 3'd0);
      gate_done = 1'b1;
      tick_chk("rst_after");
      tick_chk("rst_after");

      // Random traffic against the model
      reset_dut();
      for (int n = 0; n < 3000; n++) begin
         arrive      = ($urandom_range(0, 1) == 0);
         gate_done   = ($urandom_range(0, 2) == 0);
         depart      = ($urandom_range(0, 4) == 0);
         depart_slot = 3'($urandom_range(0, 7));
         tick_chk("rand");
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/slot_tracker.md
# slot_tracker

Occupancy tracker for the 8-space lot, located directly upstream of the ones_counter stage. It accepts arrival and departure events, allocates the lowest-numbered free space to each arriving car, and drives the entry gate through a request/done handshake with timeout. It maintains the registered 8-bit occupancy bitmap `new_capacity`, which the ones_counter converts into the `parked` count.

## Interface
- GATE_TIMEOUT, 15: maximum number of cycles `gate_open` stays high waiting for `gate_done`; legal range 1..15.
- clk  in  1  single system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- arrive  in  1  one-cycle pulse: a car is at the entry sensor.
- gate_done  in  1  one-cycle pulse from the gate: the car has passed.
- depart  in  1  one-cycle pulse: a car has left the space given by `depart_slot`.
- depart_slot  in  3  index of the departing space; valid only with `depart`.
- new_capacity  out  8  registered occupancy bitmap; bit i = 1 means space i is occupied.
- assigned_slot  out  3  space allocated to the car currently at the gate.
- gate_open  out  1  registered command to the entry gate.
- full  out  1  combinational; equals &new_capacity.
- reject  out  1  one-cycle pulse: an arrival was dropped.
- timeout  out  1  one-cycle pulse: the gate handshake was abandoned.
- depart_err  out  1  one-cycle pulse: a departure named an already-free space.

## Operation
- States are IDLE, OPEN and CLOSE. Reset enters IDLE.
- IDLE
  - On `arrive` with `full`=0: latch the lowest-index 0 bit of `new_capacity` into `assigned_slot`, clear the timeout counter, and go to OPEN.
  - On `arrive` with `full`=1: pulse `reject` and stay in IDLE.
- OPEN
  - `gate_open`=1 throughout.
  - On `gate_done`: set bit `assigned_slot` of `new_capacity` and go to CLOSE.
  - Otherwise, increment the counter. If GATE_TIMEOUT cycles in OPEN pass without `gate_done`, pulse `timeout`, leave the bitmap unchanged, and go to CLOSE.
  - If `gate_done` arrives in the final permitted cycle, it wins over timeout.
- CLOSE
  - Lasts one cycle with `gate_open`=0, then returns to IDLE.
- `arrive` in OPEN or CLOSE: pulse `reject` and ignore the arrival. There is no queueing.
- `gate_done` outside OPEN is ignored.
- `depart` is accepted in every state.
  - If bit `depart_slot` is 1, clear it.
  - If the bit is 0, pulse `depart_err` and leave the bitmap unchanged.
  - A departure naming the reserved but not yet committed `assigned_slot` is an error.
- Bitmap update: next = (cur | set_mask) & ~clr_mask. A commit and a depart in the same cycle both take effect.
- Arrival allocation uses the bitmap registered before any same-cycle departure. A space freed in cycle N is allocatable from cycle N+1.

## Timing
- Reset values:
  - state IDLE
  - `new_capacity`=8'h00
  - `assigned_slot`=0
  - `gate_open`=0
  - `reject`, `timeout`, `depart_err` = 0
  - counter 0
  - `full`=0
- `arrive` sampled at edge N sets `gate_open`=1 and `assigned_slot` valid from N+1.
- `gate_done` sampled at edge M:
  - bitmap bit set and `gate_open`=0 from M+1
  - IDLE from M+2
  - earliest next accepted arrival sampled at M+2
- Timeout: `gate_open` is high for exactly GATE_TIMEOUT cycles. `timeout` pulses in the first cycle after that, concurrently with CLOSE.
- Pulse outputs are registered, high for one cycle in the cycle after the triggering input.
- `depart` sampled at edge N clears the bit from N+1.
- `full` follows `new_capacity` combinationally, with no extra latency.
- Asserting `rst_n` mid-handshake immediately drops `gate_open`, clears the bitmap, and returns to IDLE. No reservation survives reset.

## Structure
- Shared package `parking_pkg`:
  - NUM_SLOTS=8, SLOT_W=3
  - state enum {IDLE, OPEN, CLOSE}
  - TIMER_W=4
- Sub-module `lowest_free_slot`:
  - combinational priority encoder
  - input 8-bit bitmap; outputs 3-bit index and `none_free`
  - index 0 has highest priority

## Test plan
- Reset, then `arrive`, then `gate_done` 3 cycles later → `assigned_slot`=0, `gate_open` high 3 cycles, `new_capacity`=8'h01, then 8'h03 after a second identical sequence.
- Preload 8'hFF via 8 arrival/done sequences, then `arrive` → `full`=1, `reject` pulse, `gate_open` stays 0. Then `depart` slot 5 → `new_capacity`=8'hDF, and the next arrival gets `assigned_slot`=5.
- `arrive` with no `gate_done` → `gate_open` high exactly 15 cycles, one `timeout` pulse, bitmap unchanged. A `gate_done` on cycle 15 instead commits with no timeout.
- Bitmap 8'h05, `depart` slot 1 → `depart_err` pulse, bitmap stays 8'h05.
- `gate_done` (slot 1) and `depart` slot 0 in the same cycle → bitmap 8'h05 becomes 8'h06. An `arrive` during OPEN → `reject` with no state change.
- `rst_n` low during OPEN with bitmap 8'h3C → immediately `gate_open`=0 and `new_capacity`=8'h00. After release, `arrive` gets slot 0.
